// File: rtl/ripple_carry_comparator.sv
// Unsigned magnitude comparator built from a ripple chain of 1-bit compare
// slices running LSB to MSB. Cascade inputs let several instances be chained
// into wider comparisons; the final flags are registered (one cycle latency).
module ripple_carry_comparator #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             gti,
    input  logic             lti,
    input  logic             eqi,
    output logic             gto,
    output logic             lto,
    output logic             eqo
);

    // Element i of each chain is the cascade entering slice i; element WIDTH
    // is the combinational result of the whole word.
    logic [WIDTH:0] gt_chain;
    logic [WIDTH:0] lt_chain;
    logic [WIDTH:0] eq_chain;

    assign gt_chain[0] = gti;
    assign lt_chain[0] = lti;
    assign eq_chain[0] = eqi;

    // One compare slice per bit: a differing bit overrides everything below
    // it, equal bits pass the lower-significance verdict through untouched,
    // so the most-significant differing bit ends up deciding the result.
    // Illegal cascade patterns are deliberately not cleaned up here.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        logic bit_equal;
        assign bit_equal       = ~(A[i] ^ B[i]);
        assign gt_chain[i + 1] = (A[i] & ~B[i]) | (bit_equal & gt_chain[i]);
        assign lt_chain[i + 1] = (~A[i] & B[i]) | (bit_equal & lt_chain[i]);
        assign eq_chain[i + 1] = bit_equal & eq_chain[i];
    end

    // Result register: reset reports "equal", otherwise capture the chain
    // output on every rising edge (no enable).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gto <= 1'b0;
            lto <= 1'b0;
            eqo <= 1'b1;
        end else begin
            gto <= gt_chain[WIDTH];
            lto <= lt_chain[WIDTH];
            eqo <= eq_chain[WIDTH];
        end
    end

endmodule

// File: tb/tb_ripple_carry_comparator.sv
// Self-checking bench for ripple_carry_comparator: a behavioural reference
// (plain integer compare plus cascade pass-through) checked every cycle,
// directed literal cases, async reset behaviour and a two-instance chain.
module tb_ripple_carry_comparator;

    localparam int WIDTH = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] A   = '0;
    logic [WIDTH-1:0] B   = '0;
    logic             gti = 1'b0;
    logic             lti = 1'b0;
    logic             eqi = 1'b1;
    logic             gto;
    logic             lto;
    logic             eqo;

    // Two-instance 12-bit chain
    logic [11:0]      ca = '0;
    logic [11:0]      cb = '0;
    logic             lo_gt;
    logic             lo_lt;
    logic             lo_eq;
    logic             hi_gt;
    logic             hi_lt;
    logic             hi_eq;

    int               tests    = 0;
    int               failures = 0;
    logic             check_enable = 1'b0;
    logic [2:0]       exp_out;

    ripple_carry_comparator #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B),
        .gti(gti), .lti(lti), .eqi(eqi),
        .gto(gto), .lto(lto), .eqo(eqo)
    );

    ripple_carry_comparator #(.WIDTH(6)) chain_lo (
        .clk(clk), .rst(rst), .A(ca[5:0]), .B(cb[5:0]),
        .gti(1'b0), .lti(1'b0), .eqi(1'b1),
        .gto(lo_gt), .lto(lo_lt), .eqo(lo_eq)
    );

    ripple_carry_comparator #(.WIDTH(6)) chain_hi (
        .clk(clk), .rst(rst), .A(ca[11:6]), .B(cb[11:6]),
        .gti(lo_gt), .lti(lo_lt), .eqi(lo_eq),
        .gto(hi_gt), .lto(hi_lt), .eqo(hi_eq)
    );

    always #5 clk = ~clk;

    // Reference verdict: numeric compare, cascade inputs verbatim on a tie
    function automatic logic [2:0] ref_compare(int a, int b, logic g, logic l, logic e);
        if (a > b) return 3'b100;
        if (a < b) return 3'b010;
        return {g, l, e};
    endfunction

    // Model register: one cycle of latency, async reset to "equal"
    always @(posedge clk or posedge rst) begin
        if (rst) exp_out <= 3'b001;
        else     exp_out <= ref_compare(int'(A), int'(B), gti, lti, eqi);
    end

    // Every-cycle comparison of the DUT against the model, mid-cycle
    always @(negedge clk) begin
        if (check_enable) begin
            tests++;
            if ({gto, lto, eqo} !== exp_out) begin
                failures++;
                $display("[TB] FAIL model_cmp t=%0t A=%0d B=%0d got g/l/e=%b expected %b",
                         $time, A, B, {gto, lto, eqo}, exp_out);
            end
        end
    end

    // Drive new operands shortly after a rising edge
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic g, input logic l, input logic e);
        @(posedge clk);
        #2;
        A   = a;
        B   = b;
        gti = g;
        lti = l;
        eqi = e;
    endtask

    // Compare DUT outputs against a literal expectation right now
    task automatic checkNow(input string name, input logic [2:0] want);
        tests++;
        if ({gto, lto, eqo} !== want) begin
            failures++;
            $display("[TB] FAIL %s got g/l/e=%b expected %b", name, {gto, lto, eqo}, want);
        end
    endtask

    // Wait for the edge that loads the stimulus, then check the literal
    task automatic checkOutput(input string name, input logic [2:0] want);
        @(posedge clk);
        #1;
        checkNow(name, want);
    endtask

    // Drive the chained pair and give the cascade two edges to settle
    task automatic checkChain(input string name, input logic [11:0] a,
                              input logic [11:0] b, input logic [2:0] want);
        @(posedge clk);
        #2;
        ca = a;
        cb = b;
        @(posedge clk);
        @(posedge clk);
        #1;
        tests++;
        if ({hi_gt, hi_lt, hi_eq} !== want) begin
            failures++;
            $display("[TB] FAIL %s got g/l/e=%b expected %b", name, {hi_gt, hi_lt, hi_eq}, want);
        end
    endtask

    initial begin
        #1;
        rst = 1'b1;
        #1;
        checkNow("reset_state", 3'b001);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        check_enable = 1'b1;

        // Directed cases with hand-computed results
        applyStimulus(6'd28, 6'd57, 1'b0, 1'b0, 1'b1); checkOutput("lt_28_57", 3'b010);
        applyStimulus(6'd57, 6'd28, 1'b0, 1'b0, 1'b1); checkOutput("gt_57_28", 3'b100);
        applyStimulus(6'd32, 6'd31, 1'b0, 1'b0, 1'b1); checkOutput("msb_32_31", 3'b100);
        applyStimulus(6'd45, 6'd45, 1'b0, 1'b0, 1'b1); checkOutput("eq_45", 3'b001);
        applyStimulus(6'd45, 6'd45, 1'b1, 1'b0, 1'b0); checkOutput("casc_gt", 3'b100);
        applyStimulus(6'd45, 6'd45, 1'b0, 1'b1, 1'b0); checkOutput("casc_lt", 3'b010);
        applyStimulus(6'd45, 6'd44, 1'b0, 1'b1, 1'b0); checkOutput("override", 3'b100);
        applyStimulus(6'd63, 6'd0, 1'b0, 1'b0, 1'b1);  checkOutput("gt_63_0", 3'b100);
        applyStimulus(6'd0, 6'd63, 1'b0, 1'b0, 1'b1);  checkOutput("lt_0_63", 3'b010);
        applyStimulus(6'd0, 6'd0, 1'b0, 1'b0, 1'b1);   checkOutput("eq_0", 3'b001);
        applyStimulus(6'd63, 6'd63, 1'b0, 1'b0, 1'b1); checkOutput("eq_63", 3'b001);
        applyStimulus(6'd20, 6'd20, 1'b1, 1'b1, 1'b0); checkOutput("illegal_casc", 3'b110);

        // Latency: a mid-cycle operand change must not reach the outputs
        applyStimulus(6'd57, 6'd28, 1'b0, 1'b0, 1'b1); checkOutput("lat_setup", 3'b100);
        #1;
        A = 6'd0;
        B = 6'd63;
        #1;
        checkNow("lat_hold", 3'b100);
        checkOutput("lat_update", 3'b010);

        // Async reset between edges while gto is high
        applyStimulus(6'd57, 6'd28, 1'b0, 1'b0, 1'b1); checkOutput("rst_setup", 3'b100);
        #1;
        rst = 1'b1;
        #1;
        checkNow("rst_async", 3'b001);
        repeat (2) @(posedge clk);
        #1;
        checkNow("rst_held", 3'b001);
        #1;
        rst = 1'b0;
        checkOutput("rst_release", 3'b100);

        // Randomised operands and cascades against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic [2:0]       rc;
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
            rc = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b001;
            applyStimulus(ra, rb, rc[2], rc[1], rc[0]);
            if ($urandom_range(0, 49) == 0) begin
                #1;
                rst = 1'b1;
                @(posedge clk);
                #2;
                rst = 1'b0;
            end
        end

        // Chained 12-bit compare
        checkChain("chain_lt", 12'h03F, 12'h040, 3'b010);
        checkChain("chain_lo_decides", 12'h7C5, 12'h7C2, 3'b100);
        checkChain("chain_eq", 12'hA5A, 12'hA5A, 3'b001);

        @(negedge clk);
        check_enable = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
